moving_avg: RTL
===============

MOVING_AVG -- requirements
Module: moving_avg

Interface
REQ-001 The block SHALL have parameter W, default 12, sample width in bits.
REQ-002 The block SHALL have parameter LOG2M, default 3, log2 of window length M (M = 2^LOG2M, default 8).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit, sample strobe; x is accepted on a rising edge where en=1.
REQ-006 The block SHALL have port clr, input, 1 bit, synchronous restart of the window.
REQ-007 The block SHALL have port x, input, W bits, unsigned input sample.
REQ-008 The block SHALL have port y, output, W bits, unsigned windowed average, registered.
REQ-009 The block SHALL have port y_valid, output, 1 bit, one-cycle pulse qualifying y.
REQ-010 The block SHALL have port primed, output, 1 bit, level high once the window holds M real samples.

Function
REQ-011 Each accepted sample SHALL shift into an M-deep history: h[0] <= x, h[i] <= h[i-1], and the oldest h[M-1] is discarded.
REQ-012 On the same edge, the running sum SHALL update as sum <= sum + x - h[M-1], using a W+LOG2M bit register that never overflows.
REQ-013 Stage 2: on the edge after an accept, y SHALL load sum >> LOG2M (floor truncation, no rounding).
REQ-014 Latency SHALL be 2 edges: x is accepted at edge k, and y reflects x after edge k+1.
REQ-015 With en=0, history, sum and fill count SHALL hold; y SHALL hold its last value; y_valid SHALL be 0.
REQ-016 The state machine SHALL have two states, FILL and RUN. FILL: fill count increments per accept. FILL->RUN on the accept that brings the count to M. RUN -> FILL only on clr or rst.
REQ-017 primed SHALL equal (state == RUN), registered.
REQ-018 y_valid SHALL be 1 for exactly one cycle after edge k+1 for every sample accepted in RUN, including the sample that completes the fill; it SHALL never assert for samples accepted in FILL.
REQ-019 In FILL, empty history slots SHALL be zero, so the sum holds only real samples.
REQ-020 Back-to-back accepts (en held high) SHALL produce y_valid high on consecutive cycles without stall.
REQ-021 clr=1 at an edge SHALL zero history, sum and fill count and set state to FILL; y, y_valid and primed SHALL go to 0 on that edge.
REQ-022 clr and en both high SHALL be resolved in favour of clr; the sample is dropped.
REQ-023 A pending stage-2 update SHALL be cancelled by clr; no y_valid follows a clr.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force history, sum, fill count, y and y_valid to 0, primed to 0 and state to FILL.
REQ-025 rst asserted mid-stream SHALL discard all in-flight data; the first accept after release starts a fresh fill.

Structure
REQ-026 Package filt_pkg SHALL hold the W and LOG2M defaults, the derived constants M and SUMW = W+LOG2M, and the FILL/RUN state type.
REQ-027 The M-deep delay line SHALL be a sub-module sample_shift_reg (ports clk, rst, en, clr, din, dout_oldest).
REQ-028 moving_avg SHALL own the sum, FSM and output stage.

Verification
REQ-029 Reset, then x=100 with en high for 8 cycles: y_valid SHALL first pulse after the 8th accept with y=100; primed SHALL rise on the 8th accept edge.
REQ-030 Primed on 0s, then x=4095 continuously: y SHALL read 511, 1023, 1535, 2047, 2559, 3071, 3583, 4095, with sum peaking at 32760 and no wrap.
REQ-031 Samples 1..8 (M=8): final y SHALL be 4 (36/8 truncated).
REQ-032 en pulsed every 3rd cycle with the same data as REQ-030: y values SHALL be identical, with each y_valid pulse exactly one cycle wide and one edge after its accept.
REQ-033 After primed, clr and en high together with x=999: primed SHALL drop, no y_valid SHALL follow, and the next 8 accepts SHALL be needed before y_valid.
REQ-034 rst pulsed between clock edges mid-stream: y, y_valid and primed SHALL read 0 before the next edge.

Source files
------------

// File: rtl/filt_pkg.sv
// filt_pkg: shared defaults, derived constants and state type for the moving-average filter
package filt_pkg;
  localparam int DEF_W = 12;
  localparam int DEF_LOG2M = 3;
  localparam int DEF_M = 1 << DEF_LOG2M;
  localparam int DEF_SUMW = DEF_W + DEF_LOG2M;
  typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/sample_shift_reg.sv
// sample_shift_reg: DEPTH-deep sample history exposing the oldest entry
module sample_shift_reg
  import filt_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DEPTH = DEF_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout_oldest
);
  logic [DEPTH-1:0][W-1:0] h;
  always_ff @(posedge clk or posedge rst)
    if (rst) h <= '0;
    else if (clr) h <= '0;
    else if (en) h <= {h[DEPTH-2:0], din};
  assign dout_oldest = h[DEPTH-1];
endmodule

// File: rtl/moving_avg.sv
// moving_avg: 2^LOG2M-sample boxcar average with running sum, fill FSM and registered output
module moving_avg
  import filt_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int LOG2M = DEF_LOG2M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         y_valid,
  output logic         primed
);
  localparam int M = 1 << LOG2M;
  localparam int SW = W + LOG2M;
  state_t state, state_nx;
  logic [LOG2M-1:0] cnt;
  logic [SW-1:0] sum;
  logic [W-1:0] oldest;
  logic acc, full, pend, vpend;
  sample_shift_reg #(.W(W), .DEPTH(M)) u_hist (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(x), .dout_oldest(oldest)
  );
  assign acc = en & ~clr;
  assign full = acc & (state == FILL) & (cnt == '1);
  always_comb begin
    state_nx = state;
    state_nx = clr ? FILL : (full ? RUN : state);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FILL;
    else state <= state_nx;
  // cnt wraps to zero on the filling accept and is idle in RUN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sum <= '0;
      pend <= 1'b0;
      vpend <= 1'b0;
      y <= '0;
      y_valid <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sum <= '0;
      pend <= 1'b0;
      vpend <= 1'b0;
      y <= '0;
      y_valid <= 1'b0;
    end else begin
      pend <= acc;
      vpend <= acc & ((state == RUN) | full);
      y_valid <= vpend;
      if (pend) y <= W'(sum >> LOG2M);
      if (acc) sum <= sum + SW'(x) - SW'(oldest);
      if (acc && state == FILL) cnt <= cnt + 1'b1;
    end
  assign primed = (state == RUN);
endmodule
